fetch_stage: RTL and testbench

- Instruction-fetch stage of the RV32I pipeline, directly upstream of the IF/ID buffer registers.
- Owns the PC and drives a synchronous instruction memory with 1-cycle read latency.
- Presents {pc, instr, valid} to the IF/ID registers, whose load is ~stall.
- Handles pipeline stall with a one-entry hold register so no returning instruction is lost, and handles branch/jump redirect with a one-bubble kill.

---
 rtl/fetch_stage.sv | 177 +++++++++++++++++
 tb/tb_fetch_stage.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage of the RV32I pipeline. Owns the PC, drives a
// synchronous instruction memory with one cycle of read latency, and presents
// {pc, instr, valid} to the IF/ID registers (which load when stall_i is low).
//
// A fetch issued in cycle N returns its data on imem_rdata_i in cycle N+1.
// If IF/ID stalls in the cycle that data returns, the data would be lost
// because the memory is not re-read. A one-entry hold register captures it.
// A redirect from EX costs exactly one bubble: the cycle of the redirect
// presents a NOP and issues the target, and the target is valid next cycle.
//
// Ports:
//   clk            pipeline clock, rising edge
//   clr            asynchronous active-low reset
//   stall_i        IF/ID not loading this cycle; hold fetch
//   redirect_i     taken branch/jump from EX; flush and refetch
//   redirect_pc_i  redirect target (low two bits ignored)
//   imem_req_o     read strobe to instruction memory
//   imem_addr_o    word-aligned read address
//   imem_rdata_i   read data for the request issued in the previous cycle
//   if_pc_o        PC of the presented instruction
//   if_instr_o     presented instruction (NOP_INSTR when invalid)
//   if_valid_o     presented instruction is real, not a bubble
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic [XLEN-1:0] if_pc_o,
  output logic [XLEN-1:0] if_instr_o,
  output logic            if_valid_o
);

  localparam logic [XLEN-1:0] AlignMask = {{(XLEN-2){1'b1}}, 2'b00};
  localparam logic [XLEN-1:0] PcStep    = XLEN'(4);

  typedef enum logic [1:0] {
    StEmpty,  // nothing in flight, nothing held
    StRun,    // a response returns this cycle
    StHold    // a returned instruction waits in the hold register
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            resp_vld_q, resp_vld_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic            hold_vld_q, hold_vld_d;
  logic [XLEN-1:0] hold_pc_q, hold_pc_d;
  logic [XLEN-1:0] hold_instr_q, hold_instr_d;

  logic            issue;
  logic            capture;
  logic [XLEN-1:0] fetch_addr;
  logic [XLEN-1:0] redirect_aligned;
  logic [XLEN-1:0] pc_aligned;

  assign redirect_aligned = redirect_pc_i & AlignMask;
  assign pc_aligned       = pc_q & AlignMask;

  // A response is returning and nothing is held yet: it must be saved now,
  // because the memory output is not guaranteed to persist past this cycle.
  assign capture = resp_vld_q & ~hold_vld_q;

  // -------------------------------------------------------------------------
  // Next-state logic. Priority: redirect > stall > normal advance.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    resp_vld_d   = resp_vld_q;
    resp_pc_d    = resp_pc_q;
    hold_vld_d   = hold_vld_q;
    hold_pc_d    = hold_pc_q;
    hold_instr_d = hold_instr_q;
    issue        = 1'b0;
    fetch_addr   = pc_aligned;

    if (redirect_i) begin
      // Flush anything in flight or held; the stall is overridden.
      issue      = 1'b1;
      fetch_addr = redirect_aligned;
      pc_d       = redirect_aligned + PcStep;
      resp_vld_d = 1'b1;
      resp_pc_d  = redirect_aligned;
      hold_vld_d = 1'b0;
      state_d    = StRun;
    end else if (!stall_i) begin
      // Any held instruction is consumed by IF/ID this cycle.
      issue      = 1'b1;
      pc_d       = pc_aligned + PcStep;
      resp_vld_d = 1'b1;
      resp_pc_d  = pc_aligned;
      hold_vld_d = 1'b0;
      state_d    = StRun;
    end else begin
      resp_vld_d = 1'b0;
      if (capture) begin
        hold_vld_d   = 1'b1;
        hold_pc_d    = resp_pc_q;
        hold_instr_d = imem_rdata_i;
      end
      case (state_q)
        StEmpty: state_d = StEmpty;
        StRun:   state_d = capture ? StHold : StRun;
        StHold:  state_d = StHold;
        default: state_d = StEmpty;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q      <= StEmpty;
      pc_q         <= RESET_PC;
      resp_vld_q   <= 1'b0;
      resp_pc_q    <= RESET_PC;
      hold_vld_q   <= 1'b0;
      hold_pc_q    <= RESET_PC;
      hold_instr_q <= NOP_INSTR;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      resp_vld_q   <= resp_vld_d;
      resp_pc_q    <= resp_pc_d;
      hold_vld_q   <= hold_vld_d;
      hold_pc_q    <= hold_pc_d;
      hold_instr_q <= hold_instr_d;
    end
  end

  // -------------------------------------------------------------------------
  // Memory interface. The strobe is gated by clr so no read is requested
  // while reset is asserted.
  // -------------------------------------------------------------------------
  assign imem_req_o  = clr & issue;
  assign imem_addr_o = fetch_addr;

  // -------------------------------------------------------------------------
  // Output select: hold register first, then the returning response, else a
  // bubble. A redirect turns whatever is presented into a bubble.
  // -------------------------------------------------------------------------
  always_comb begin
    if_valid_o = 1'b0;
    if_pc_o    = pc_q;
    if_instr_o = NOP_INSTR;

    if (hold_vld_q) begin
      if_valid_o = 1'b1;
      if_pc_o    = hold_pc_q;
      if_instr_o = hold_instr_q;
    end else if (resp_vld_q) begin
      if_valid_o = 1'b1;
      if_pc_o    = resp_pc_q;
      if_instr_o = imem_rdata_i;
    end

    if (redirect_i) begin
      if_valid_o = 1'b0;
      if_instr_o = NOP_INSTR;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//
// Bench for fetch_stage. The instruction memory returns addr + 0x100 one
// cycle after a request, and random garbage in cycles with no request, so a
// lost or re-read response shows up as a wrong instruction.
//
// Reference model: the stage is viewed as holding at most one fetched but
// not yet consumed instruction (m_have/m_pc) plus the next address to fetch
// (m_fetch). Each cycle a redirect replaces everything, an unstalled cycle
// consumes the current instruction and fetches the next, and a stall changes
// nothing.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

  localparam logic [31:0] ResetPc = 32'h0000_0000;
  localparam logic [31:0] Nop     = 32'h0000_0013;
  localparam logic [31:0] DataOff = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_valid;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  bit          m_have;
  logic [31:0] m_pc;
  logic [31:0] m_fetch;

  always #5 clk = ~clk;

  fetch_stage #(
    .XLEN      (32),
    .RESET_PC  (ResetPc),
    .NOP_INSTR (Nop)
  ) dut (
    .clk           (clk),
    .clr           (clr),
    .stall_i       (stall),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_rdata_i  (imem_rdata),
    .if_pc_o       (if_pc),
    .if_instr_o    (if_instr),
    .if_valid_o    (if_valid)
  );

  always @(posedge clk) begin
    if (imem_req) imem_rdata <= imem_addr + DataOff;
    else          imem_rdata <= $urandom();
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_have  = 1'b0;
    m_pc    = ResetPc;
    m_fetch = ResetPc;
  endtask

  task automatic check_model();
    logic        ev;
    logic        er;
    logic [31:0] epc;
    logic [31:0] einstr;
    logic [31:0] eaddr;
    ev     = clr && m_have && !redirect;
    er     = clr && (redirect || !stall);
    epc    = m_have ? m_pc : m_fetch;
    einstr = ev ? m_pc + DataOff : Nop;
    eaddr  = redirect ? {redirect_pc[31:2], 2'b00} : m_fetch;
    chk("model_valid", 32'(if_valid), 32'(ev));
    chk("model_pc", if_pc, epc);
    chk("model_instr", if_instr, einstr);
    chk("model_req", 32'(imem_req), 32'(er));
    if (er) chk("model_addr", imem_addr, eaddr);
    chk("addr_align", 32'(imem_addr[1:0]), 32'd0);
  endtask

  // Apply inputs away from the active edge, then check combinational outputs.
  task automatic drive(input logic c, input logic s, input logic r, input logic [31:0] t);
    @(negedge clk);
    clr         = c;
    stall       = s;
    redirect    = r;
    redirect_pc = t;
    if (!c) model_reset();
    #1;
    check_model();
  endtask

  task automatic tick();
    logic [31:0] a;
    @(posedge clk);
    if (!clr) begin
      model_reset();
    end else if (redirect) begin
      a       = {redirect_pc[31:2], 2'b00};
      m_have  = 1'b1;
      m_pc    = a;
      m_fetch = a + 32'd4;
    end else if (!stall) begin
      m_have  = 1'b1;
      m_pc    = m_fetch;
      m_fetch = m_fetch + 32'd4;
    end
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [31:0] pc,
                            input logic [31:0] instr);
    chk({tag, "_valid"}, 32'(if_valid), 32'(v));
    chk({tag, "_pc"}, if_pc, pc);
    chk({tag, "_instr"}, if_instr, instr);
  endtask

  initial begin
    model_reset();

    // Reset held: outputs idle
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    expect_out("reset", 1'b0, ResetPc, Nop);
    chk("reset_req", 32'(imem_req), 32'd0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    tick();

    // Release: cycle 1 issues, cycle 2 presents RESET_PC
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    expect_out("lat_c1", 1'b0, ResetPc, Nop);
    chk("lat_c1_req", 32'(imem_req), 32'd1);
    tick();
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    expect_out("lat_c2", 1'b1, 32'h0, 32'h100);
    tick();
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    expect_out("seq_4", 1'b1, 32'h4, 32'h104);
    tick();

    // Three-cycle stall as pc 0x8 returns
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0, 32'h0);
      expect_out("stall", 1'b1, 32'h8, 32'h108);
      chk("stall_req", 32'(imem_req), 32'd0);
      tick();
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    expect_out("release", 1'b1, 32'h8, 32'h108);
    chk("release_addr", imem_addr, 32'hC);
    tick();
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    expect_out("after_c", 1'b1, 32'hC, 32'h10C);
    tick();

    // Redirect to 0x200 while pc 0x10 is presented
    drive(1'b1, 1'b0, 1'b1, 32'h200);
    chk("redir_valid", 32'(if_valid), 32'd0);
    chk("redir_instr", if_instr, Nop);
    chk("redir_addr", imem_addr, 32'h200);
    tick();
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    expect_out("redir_tgt", 1'b1, 32'h200, 32'h300);
    tick();
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    expect_out("redir_tgt4", 1'b1, 32'h204, 32'h304);
    tick();

    // Build a hold, then redirect with stall still high
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    expect_out("hold_pend", 1'b1, 32'h208, 32'h308);
    tick();
    drive(1'b1, 1'b1, 1'b1, 32'h40);
    chk("redir_stall_valid", 32'(if_valid), 32'd0);
    chk("redir_stall_addr", imem_addr, 32'h40);
    chk("redir_stall_req", 32'(imem_req), 32'd1);
    tick();
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    expect_out("redir_stall_tgt", 1'b1, 32'h40, 32'h140);
    tick();

    // Misaligned redirect target
    drive(1'b1, 1'b0, 1'b1, 32'h103);
    chk("misalign_addr", imem_addr, 32'h100);
    tick();
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    expect_out("misalign_tgt", 1'b1, 32'h100, 32'h200);
    tick();

    // PC wrap at the top of the address space
    drive(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8);
    tick();
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    chk("wrap_addr_fc", imem_addr, 32'hFFFF_FFFC);
    tick();
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    expect_out("wrap_top", 1'b1, 32'hFFFF_FFFC, 32'h0000_00FC);
    chk("wrap_addr_0", imem_addr, 32'h0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    expect_out("wrap_zero", 1'b1, 32'h0, 32'h100);
    tick();

    // clr pulse with a hold pending
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    expect_out("pre_clr_hold", 1'b1, 32'h4, 32'h104);
    tick();
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    expect_out("clr_mid_hold", 1'b0, ResetPc, Nop);
    chk("clr_mid_req", 32'(imem_req), 32'd0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    expect_out("restart_c1", 1'b0, ResetPc, Nop);
    tick();
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    expect_out("restart_c2", 1'b1, ResetPc, ResetPc + DataOff);
    tick();

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic c;
      logic s;
      logic r;
      c = ($urandom_range(0, 99) >= 2);
      s = ($urandom_range(0, 99) < 35);
      r = ($urandom_range(0, 99) < 10);
      drive(c, s, r, $urandom());
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
